// File: rtl/core_run_sequencer.sv
// Sequences one core through reset, start and run-to-halt, one command at a time,
// posting a result code and the executed cycle count on completion.
module core_run_sequencer #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             CCLK,
    input  logic             CRST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [31:0]      CMD_ADDR,
    input  logic [CNT_W-1:0] CMD_LIMIT,
    input  logic             ABORT,
    input  logic [7:0]       CSTAT,
    output logic             CORE_RST,
    output logic             CORE_EXEC,
    output logic [31:0]      CORE_MEM_ADDR,
    output logic             BUSY,
    output logic             DONE,
    output logic [2:0]       RESULT,
    output logic [CNT_W-1:0] CYCLES
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTSEQ,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [2:0]       RES_HALT    = 3'd1;
    localparam logic [2:0]       RES_ERROR   = 3'd2;
    localparam logic [2:0]       RES_TIMEOUT = 3'd3;
    localparam logic [2:0]       RES_ABORT   = 3'd4;
    localparam logic [2:0]       RES_RSTDONE = 3'd5;
    localparam logic [2:0]       RES_BADCMD  = 3'd6;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [7:0]       RST_LOAD    = 8'(RST_CYCLES - 1);

    state_t           r_state;
    logic             r_ready;
    logic [1:0]       r_op;
    logic [CNT_W-1:0] r_limit;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_cycles;
    logic [7:0]       r_rst_cnt;
    logic [2:0]       r_result;

    state_t           w_next;
    logic             w_accept;
    logic             w_res_ld;
    logic [2:0]       w_res_val;
    logic [CNT_W-1:0] w_cyc_inc;
    logic             w_lim_hit;
    logic             w_unused_cstat;

    assign w_accept       = CMD_VALID & r_ready;
    assign w_unused_cstat = ^CSTAT[7:2];

    // Saturating increment; the limit matches on the count this RUN cycle will reach.
    assign w_cyc_inc = (r_cycles == '1) ? r_cycles : r_cycles + CNT_ONE;
    assign w_lim_hit = (r_limit != '0) && (w_cyc_inc == r_limit);

    always_comb begin
        w_next    = r_state;
        w_res_ld  = 1'b0;
        w_res_val = r_result;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (CMD_OP)
                        2'd0, 2'd1: w_next = S_RSTSEQ;
                        2'd2:       w_next = S_SETTLE;
                        default: begin
                            w_next    = S_DONE;
                            w_res_ld  = 1'b1;
                            w_res_val = RES_BADCMD;
                        end
                    endcase
                end
            end
            S_RSTSEQ: begin
                if (ABORT) begin
                    w_next    = S_DONE;
                    w_res_ld  = 1'b1;
                    w_res_val = RES_ABORT;
                end else if (r_rst_cnt == '0) begin
                    if (r_op == 2'd0) begin
                        w_next    = S_DONE;
                        w_res_ld  = 1'b1;
                        w_res_val = RES_RSTDONE;
                    end else begin
                        w_next = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (ABORT) begin
                    w_next    = S_DONE;
                    w_res_ld  = 1'b1;
                    w_res_val = RES_ABORT;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (CSTAT[1] || CSTAT[0] || ABORT || w_lim_hit) begin
                    w_next   = S_DONE;
                    w_res_ld = 1'b1;
                    if (CSTAT[1])      w_res_val = RES_ERROR;
                    else if (CSTAT[0]) w_res_val = RES_HALT;
                    else if (ABORT)    w_res_val = RES_ABORT;
                    else               w_res_val = RES_TIMEOUT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CCLK or posedge CRST) begin
        if (CRST) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_op      <= '0;
            r_limit   <= '0;
            r_addr    <= '0;
            r_cycles  <= '0;
            r_rst_cnt <= '0;
            r_result  <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
            if (w_accept) begin
                r_op      <= CMD_OP;
                r_limit   <= CMD_LIMIT;
                r_addr    <= CMD_ADDR;
                r_cycles  <= '0;
                r_rst_cnt <= RST_LOAD;
            end else begin
                if ((r_state == S_RSTSEQ) && (r_rst_cnt != '0))
                    r_rst_cnt <= r_rst_cnt - 8'd1;
                if (r_state == S_RUN)
                    r_cycles <= w_cyc_inc;
            end
            if (w_res_ld)
                r_result <= w_res_val;
        end
    end

    assign CMD_READY     = r_ready;
    assign CORE_RST      = (r_state == S_RSTSEQ);
    assign CORE_EXEC     = (r_state == S_RUN);
    assign CORE_MEM_ADDR = r_addr;
    assign BUSY          = (r_state != S_IDLE);
    assign DONE          = (r_state == S_DONE);
    assign RESULT        = r_result;
    assign CYCLES        = r_cycles;

endmodule
